fixed_div_seq: RTL and testbench
================================

Name: fixed_div_seq

Overview:
- Sequential, parametrised sign-magnitude fixed-point divider; iterative successor to the combinational reciprocal/div path.
- Computes a/b, or 1/b in reciprocal mode, by restoring shift-subtract. Result is exact (truncated) rather than a Newton-Raphson approximation.
- Uses one subtractor instead of an unrolled multiplier chain, and adds valid/ready handshakes plus divide-by-zero and overflow flags.
- Sits between neuron-equation datapath stages that need division.

Parameters:
- N, 32, total word width; bit N-1 is the sign, bits N-2:0 are the magnitude.
- Q, 16, fractional bits of the magnitude.
- ITER, derived localparam = N-1+Q, number of quotient bits computed; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block idle and able to accept operands.
- a  in  N  dividend, sign-magnitude Q format.
- b  in  N  divisor, sign-magnitude Q format.
- recip_mode  in  1  when 1, the dividend is taken as +1.0 (1<<Q) and a is ignored.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- q  out  N  quotient, sign-magnitude Q format.
- div_by_zero  out  1  b magnitude was 0.
- overflow  out  1  quotient magnitude saturated.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; q=0, out_valid=0, div_by_zero=0, overflow=0, busy=0; in_ready=1 once reset deasserts. Reset mid-division abandons the operation; no result is emitted.
- States and transitions:
  - IDLE: go to DIV on in_valid&&in_ready. If b[N-2:0]==0, go to FIN instead.
  - DIV: run ITER iterations, then go to FIN.
  - FIN: go to DONE.
  - DONE: go to IDLE on out_valid&&out_ready.
- Handshake:
  - in_ready = (state==IDLE), so only one operation is in flight.
  - Operands, recip_mode and sign = a[N-1]^b[N-1] are captured on the accept edge. In recip_mode the sign is b[N-1].
  - out_valid is high exactly in DONE. q and the flags stay stable while out_valid=1 and out_ready=0.
  - in_ready rises the cycle after the output handshake; there is no same-cycle bypass.
- Datapath:
  - Dividend D = |a| << Q, width ITER bits.
  - Remainder register R is N bits; magnitude divisor is Bm = b[N-2:0].
  - Each DIV cycle, MSB-first: R' = {R, next D bit}. If R' >= Bm, then R = R'-Bm and the quotient bit is 1; otherwise R = R' and the quotient bit is 0.
  - A 6-bit (clog2(ITER+1)) counter counts iterations 0..ITER-1.
- FIN rules:
  - If the upper Q quotient bits are nonzero: magnitude = all ones, overflow=1.
  - If magnitude==0: sign bit forced to 0 (no negative zero).
  - Divide-by-zero: magnitude = all ones, sign = a[N-1] (0 in recip_mode), div_by_zero=1, overflow=0.
- Latency, measured from the accept edge: out_valid is high after ITER+1 edges (48 at defaults). For divide-by-zero, out_valid is high after 2 edges.
- Simultaneous in_valid during DONE is ignored because in_ready=0.

Optional Feature:
- Macro FIXED_DIV_ROUND_EN.
- Defined: in FIN, if 2*R >= Bm, magnitude is incremented by 1. The increment saturates to all ones and sets overflow if it carries out. Latency is unchanged.
- Undefined: truncation toward zero.

Test Plan (defaults N=32, Q=16):
- a=0x00060000, b=0x00020000 -> q=0x00030000, flags 0, out_valid high 48 edges after accept.
- recip_mode=1, b=0x80030000 -> q=0x80005555. Repeat with a=0x00020000, b=0x00030000 -> q=0x0000AAAA, or 0x0000AAAB with FIXED_DIV_ROUND_EN.
- a=0x80050000, b=0x00000000 -> q=0xFFFFFFFF, div_by_zero=1, out_valid 2 edges after accept. Next, a=0x80000000, b=0x00010000 -> q=0x00000000.
- a=0x40000000, b=0x00000001 -> q=0x7FFFFFFF, overflow=1.
- Hold out_ready=0 for 10 cycles in DONE -> q and flags stable, in_ready=0; a new in_valid is not accepted until the cycle after the output handshake.
- Assert rst_n=0 at iteration 20 -> all outputs 0 immediately, no out_valid afterward; a fresh 6/2 division then completes correctly.

Source files
------------

// File: rtl/fixed_div_seq.sv
// Sequential sign-magnitude fixed-point divider (restoring shift-subtract, a/b or 1/b).
// Optional macro FIXED_DIV_ROUND_EN: round-half-up of the quotient magnitude instead of truncation.
module fixed_div_seq #(
  parameter int N = 32,
  parameter int Q = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         recip_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic         div_by_zero,
  output logic         overflow,
  output logic         busy
);

  localparam int ITER = N - 1 + Q;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [N-2:0] ONE_Q = (N-1)'(1) << Q;

  typedef enum logic [1:0] {IDLE, DIV, FIN, DONE} state_t;

  state_t          state;
  logic [ITER-1:0] dq;
  logic [N-1:0]    rem;
  logic [N-2:0]    bm;
  logic [CW-1:0]   cnt;
  logic            sign_r;
  logic            dz_sign;
  logic            dz_r;

  logic [N-2:0]    a_mag;
  logic [ITER-1:0] dvd;
  logic [N:0]      first_step;
  logic [N:0]      div_step;
  logic [N-2:0]    mag_fin;
  logic            ovf_fin;
  logic [N-1:0]    q_fin;

  // The remainder is always below the divisor (< 2^(N-1)), so the shifted value fits in N bits.
  function automatic logic [N:0] step(input logic [N-1:0] r, input logic din, input logic [N-2:0] d);
    logic [N-1:0] rp;
    rp = {r[N-2:0], din};
    if (rp >= {1'b0, d}) return {1'b1, rp - {1'b0, d}};
    else return {1'b0, rp};
  endfunction

  // The first quotient bit is resolved on the accept edge so the total latency is ITER+1 edges.
  always_comb begin
    a_mag      = recip_mode ? ONE_Q : a[N-2:0];
    dvd        = {a_mag, {Q{1'b0}}};
    first_step = step('0, dvd[ITER-1], b[N-2:0]);
    div_step   = step(rem, dq[ITER-1], bm);
  end

  always_comb begin
    ovf_fin = |dq[ITER-1:N-1];
    mag_fin = dq[N-2:0];
`ifdef FIXED_DIV_ROUND_EN
    if (!ovf_fin && ({rem, 1'b0} >= {2'b00, bm})) begin
      if (&mag_fin) ovf_fin = 1'b1;
      else mag_fin = mag_fin + 1'b1;
    end
`endif
    if (ovf_fin) mag_fin = '1;
    q_fin = {(mag_fin != '0) & sign_r, mag_fin};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dq          <= '0;
      rem         <= '0;
      bm          <= '0;
      cnt         <= '0;
      sign_r      <= 1'b0;
      dz_sign     <= 1'b0;
      dz_r        <= 1'b0;
      q           <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          bm      <= b[N-2:0];
          sign_r  <= recip_mode ? b[N-1] : (a[N-1] ^ b[N-1]);
          dz_sign <= recip_mode ? 1'b0 : a[N-1];
          if (b[N-2:0] == '0) begin
            dz_r  <= 1'b1;
            state <= FIN;
          end else begin
            dz_r  <= 1'b0;
            rem   <= first_step[N-1:0];
            dq    <= {dvd[ITER-2:0], first_step[N]};
            cnt   <= CW'(1);
            state <= DIV;
          end
        end
        DIV: begin
          rem <= div_step[N-1:0];
          dq  <= {dq[ITER-2:0], div_step[N]};
          if (cnt == CW'(ITER - 1)) state <= FIN;
          else cnt <= cnt + 1'b1;
        end
        FIN: begin
          if (dz_r) begin
            q           <= {dz_sign, {(N-1){1'b1}}};
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            q           <= q_fin;
            div_by_zero <= 1'b0;
            overflow    <= ovf_fin;
          end
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fixed_div_seq.sv
// Self-checking bench for fixed_div_seq: directed vector table, corner sequences and random ops vs an arithmetic model.
module tb_fixed_div_seq;

  localparam int LAT_DIV = 48;
  localparam int LAT_DZ  = 2;
`ifdef FIXED_DIV_ROUND_EN
  localparam logic [31:0] Q_2_3 = 32'h0000AAAB;
`else
  localparam logic [31:0] Q_2_3 = 32'h0000AAAA;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        recip_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] q;
  logic        div_by_zero;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        recip;
    logic [31:0] q;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  fixed_div_seq #(.N(32), .Q(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .recip_mode(recip_mode), .out_valid(out_valid),
    .out_ready(out_ready), .q(q), .div_by_zero(div_by_zero),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: magnitude quotient from plain integer division of (|a| << 16) by |b|.
  task automatic model(input logic [31:0] ai, input logic [31:0] bi, input logic recip,
                       output logic [31:0] qe, output logic dz, output logic ov);
    longint unsigned am, bmag, d, quo, r;
    logic s;
    bmag = longint'(bi[30:0]);
    if (bmag == 0) begin
      dz = 1'b1;
      ov = 1'b0;
      qe = {recip ? 1'b0 : ai[31], 31'h7FFFFFFF};
      return;
    end
    dz  = 1'b0;
    am  = recip ? 64'd65536 : longint'(ai[30:0]);
    d   = am << 16;
    quo = d / bmag;
    r   = d % bmag;
    ov  = (quo > 64'h7FFFFFFF);
`ifdef FIXED_DIV_ROUND_EN
    if (!ov && (2 * r >= bmag)) quo = quo + 1;
    if (quo > 64'h7FFFFFFF) ov = 1'b1;
`endif
    if (ov) quo = 64'h7FFFFFFF;
    s  = recip ? bi[31] : (ai[31] ^ bi[31]);
    if (quo == 0) s = 1'b0;
    qe = {s, quo[30:0]};
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] ai, input logic [31:0] bi, input logic recip,
                                input logic [31:0] eq, input logic edz, input logic eov,
                                input int elat, input string name);
    int n, lat;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_ready"}, in_ready, 1);
    a = ai; b = bi; recip_mode = recip; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    chk({name, "_lat"}, lat, elat);
    check_output(name, eq, edz, eov);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [31:0] eq, input logic edz, input logic eov);
    chk({name, "_q"}, q, eq);
    chk({name, "_dz"}, div_by_zero, edz);
    chk({name, "_ov"}, overflow, eov);
  endtask

  initial begin
    logic [31:0] ra, rb, eq;
    logic        rr, edz, eov;
    int          lat, bad, seen;

    vecs[0] = '{32'h00060000, 32'h00020000, 1'b0, 32'h00030000, 1'b0, 1'b0, LAT_DIV};
    vecs[1] = '{32'h00000000, 32'h80030000, 1'b1, 32'h80005555, 1'b0, 1'b0, LAT_DIV};
    vecs[2] = '{32'h00020000, 32'h00030000, 1'b0, Q_2_3,        1'b0, 1'b0, LAT_DIV};
    vecs[3] = '{32'h80050000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, LAT_DZ};
    vecs[4] = '{32'h80000000, 32'h00010000, 1'b0, 32'h00000000, 1'b0, 1'b0, LAT_DIV};
    vecs[5] = '{32'h40000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, LAT_DIV};
    vecs[6] = '{32'h12345678, 32'h80000000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, LAT_DZ};
    vecs[7] = '{32'h80060000, 32'h00020000, 1'b0, 32'h80030000, 1'b0, 1'b0, LAT_DIV};

    #2;
    chk("rst_q", q, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {div_by_zero, overflow}, 0);
    chk("rst_in_ready_low", in_ready, 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready_high", in_ready, 1);

    for (int i = 0; i < 8; i++)
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].recip, vecs[i].q, vecs[i].dz, vecs[i].ov,
                     vecs[i].lat, $sformatf("vec%0d", i));

    // Backpressure in DONE, with a competing request that must wait for the handshake.
    a = 32'h00060000; b = 32'h00020000; recip_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp_lat", lat, LAT_DIV);
    a = 32'h000A0000; b = 32'h00020000; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (q !== 32'h00030000 || out_valid !== 1'b1 || in_ready !== 1'b0 ||
          div_by_zero !== 1'b0 || overflow !== 1'b0) bad++;
    end
    chk("bp_stable", bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_out_valid_after", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted_busy", busy, 1);
    wait_out(lat);
    chk("bp2_lat", lat, LAT_DIV);
    check_output("bp2", 32'h00050000, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a division abandons it.
    a = 32'h00060000; b = 32'h00020000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_q", q, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mid_rst_no_output", seen, 0);
    apply_stimulus(32'h00060000, 32'h00020000, 1'b0, 32'h00030000, 1'b0, 1'b0, LAT_DIV, "post_rst");

    // Random operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rr = 1'b0;
      case ($urandom_range(0, 3))
        0: rb = rb & 32'h8000000F;
        1: begin rb = rb & 32'h80FFFFFF; ra = ra & 32'h800FFFFF; end
        2: ;
        default: rr = 1'b1;
      endcase
      if ($urandom_range(0, 15) == 0) rb = rb & 32'h80000000;
      model(ra, rb, rr, eq, edz, eov);
      apply_stimulus(ra, rb, rr, eq, edz, eov, edz ? LAT_DZ : LAT_DIV, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
